// File: rtl/data_sram_responder.sv
// Word-addressed data SRAM with a small MMIO window (LED, store counter) at 0xBFAF_xxxx.
// Define SRAM_RESP_TIMER_EN to add a free-running writable TIMER at MMIO offset 0xE000.
module data_sram_responder #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    localparam int unsigned Depth     = 1 << ADDR_W;
    localparam logic [15:0] MmioBase  = 16'hBFAF;
    localparam logic [15:0] OffLed    = 16'hF000;
    localparam logic [15:0] OffStCnt  = 16'hF200;
    localparam logic [15:0] OffTimer  = 16'hE000;

    logic [31:0]       mem [Depth];
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       mmio_off;
    logic              is_mmio;
    logic              wr_any;
    logic              ram_we;
    logic              led_we;
    logic [31:0]       wmask;
    logic [31:0]       store_cnt_q;
    logic [31:0]       mmio_rdata;

    assign word_idx = data_sram_addr[ADDR_W+1:2];
    assign mmio_off = data_sram_addr[15:0];
    assign is_mmio  = (data_sram_addr[31:16] == MmioBase);
    // Accesses presented during reset are dropped entirely.
    assign wr_any   = data_sram_en && (data_sram_wen != 4'b0000) && !rst;
    assign ram_we   = wr_any && !is_mmio;
    assign led_we   = wr_any && is_mmio && (mmio_off == OffLed);
    assign wmask    = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                       {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] timer_q;
    logic        timer_we;

    assign timer_we = wr_any && is_mmio && (mmio_off == OffTimer);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 32'h0;
        end else if (timer_we) begin
            timer_q <= (timer_q & ~wmask) | (data_sram_wdata & wmask);
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`endif

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OffLed:   mmio_rdata = {16'h0, led};
            OffStCnt: mmio_rdata = store_cnt_q;
`ifdef SRAM_RESP_TIMER_EN
            OffTimer: mmio_rdata = timer_q;
`endif
            default:  mmio_rdata = 32'h0;
        endcase
    end

    // RAM is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first: a write cycle returns the word's old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= 32'h0;
        end else if (data_sram_en) begin
            data_sram_rdata <= is_mmio ? mmio_rdata : mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0;
        end else if (led_we) begin
            led <= (led & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_cnt_q <= 32'h0;
        end else if (ram_we && (store_cnt_q != 32'hFFFF_FFFF)) begin
            store_cnt_q <= store_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder against a per-cycle reference model.
// Compile with SRAM_RESP_TIMER_EN defined to cover the TIMER register.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;

    data_sram_responder #(.ADDR_W(12)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic [31:0] cnt_m;
    logic [31:0] timer_m;
    logic [31:0] exp_rdata;

    int n_vec;
    int n_err;

    int pool [8] = '{0, 1, 2, 3, 'h400, 'h7FF, 'hC00, 'hFFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (a[31:16] == 16'hBFAF) begin
            if (a[15:0] == 16'hF000) return {16'h0, led_m};
            if (a[15:0] == 16'hF200) return cnt_m;
`ifdef SRAM_RESP_TIMER_EN
            if (a[15:0] == 16'hE000) return timer_m;
`endif
            return 32'h0;
        end
        idx = int'(a[13:2]);
        return ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
    endfunction

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        logic mmio;
        logic wr;
        int   idx;
        rst = r; data_sram_en = e; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
        mmio = (a[31:16] == 16'hBFAF);
        wr   = e && (w != 4'b0) && !r;
        idx  = int'(a[13:2]);
        if (r) begin
            exp_rdata = 32'h0;
            led_m     = 16'h0;
            cnt_m     = 32'h0;
            timer_m   = 32'h0;
        end else begin
            if (e) exp_rdata = model_read(a);
`ifdef SRAM_RESP_TIMER_EN
            if (wr && mmio && a[15:0] == 16'hE000) timer_m = merge(timer_m, d, w);
            else timer_m = timer_m + 32'd1;
`endif
            if (wr && mmio && a[15:0] == 16'hF000)
                led_m = merge({16'h0, led_m}, d, {2'b00, w[1:0]}) & 32'hFFFF;
            if (wr && !mmio) begin
                ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 32'h0, d, w);
                if (cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        check("rdata", data_sram_rdata, exp_rdata);
        check("led", {16'h0, led}, {16'h0, led_m});
    endtask

    function automatic logic [31:0] rand_ram_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_C000) | (32'(pool[$urandom_range(0, 7)]) << 2)
            | 32'($urandom_range(0, 3));
        if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0000;
        return a;
    endfunction

    function automatic logic [31:0] rand_mmio_addr();
        case ($urandom_range(0, 3))
            0: return 32'hBFAF_F000;
            1: return 32'hBFAF_F200;
            2: return 32'hBFAF_E000;
            default: return {16'hBFAF, 16'($urandom)};
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        n_vec = 0;
        n_err = 0;
        led_m = 16'h0; cnt_m = 32'h0; timer_m = 32'h0; exp_rdata = 32'h0;

        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);

        // Initialize every word the bench ever reads; first write right after reset.
        foreach (pool[i]) step(0, 1, 4'hF, 32'(pool[i]) << 2, $urandom);

        // Full write then read
        step(0, 1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        step(0, 1, 4'h0, 32'h0000_1000, 32'h0);
        check("full_write_read", data_sram_rdata, 32'hDEAD_BEEF);

        // Partial write, read-first, merge on back-to-back read
        step(0, 1, 4'b0010, 32'h0000_1000, 32'h0000_5500);
        check("read_first", data_sram_rdata, 32'hDEAD_BEEF);
        step(0, 1, 4'h0, 32'h0000_1000, 32'h0);
        check("byte_merge", data_sram_rdata, 32'hDEAD_55EF);

        // Aliasing and en=0 hold
        step(0, 1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D);
        step(0, 1, 4'h0, 32'h0000_0000, 32'h0);
        check("alias", data_sram_rdata, 32'hCAFE_F00D);
        step(0, 0, 4'hF, 32'h0000_0004, 32'h1111_1111);
        check("en0_hold", data_sram_rdata, 32'hCAFE_F00D);

        // LED register; RAM word sharing the low offset untouched
        step(0, 1, 4'hF, 32'h0000_F000, 32'h5A5A_0001);
        step(0, 1, 4'hF, 32'hBFAF_F000, 32'h1234_ABCD);
        check("led_value", {16'h0, led}, 32'h0000_ABCD);
        step(0, 1, 4'h0, 32'hBFAF_F000, 32'h0);
        check("led_read", data_sram_rdata, 32'h0000_ABCD);
        step(0, 1, 4'h0, 32'h0000_F000, 32'h0);
        check("mmio_no_ram", data_sram_rdata, 32'h5A5A_0001);
        step(0, 1, 4'hF, 32'hBFAF_1234, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, 32'hBFAF_1234, 32'h0);
        check("unmapped", data_sram_rdata, 32'h0);

        // Store counter; write under reset discarded
        step(1, 1, 4'hF, 32'h0000_0008, 32'hBAD0_BAD0);
        step(0, 1, 4'hF, 32'h0000_000C, 32'h0000_0003);
        step(0, 1, 4'hF, 32'h0000_0010, 32'h0000_0004);
        step(0, 1, 4'hF, 32'h0000_0014, 32'h0000_0005);
        step(0, 1, 4'h3, 32'hBFAF_F000, 32'h0000_7777);
        step(0, 1, 4'h0, 32'hBFAF_F200, 32'h0);
        check("store_cnt", data_sram_rdata, 32'd3);
        step(0, 1, 4'h0, 32'h0000_0008, 32'h0);
        check("rst_write_dropped", data_sram_rdata, ram_m[2]);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_rdata", data_sram_rdata, 32'h0);
        step(0, 1, 4'h0, 32'h0000_0010, 32'h0);
        check("ram_retained", data_sram_rdata, 32'h0000_0004);

        // Timer write and wrap
        step(0, 1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, 32'hBFAF_E000, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
        check("timer_load", data_sram_rdata, 32'hFFFF_FFFF);
`else
        check("timer_absent", data_sram_rdata, 32'h0);
`endif
        step(0, 1, 4'h0, 32'hBFAF_E000, 32'h0);
        check("timer_wrap", data_sram_rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        e;
            logic [3:0]  w;
            logic [31:0] a;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            a = ($urandom_range(0, 9) < 7) ? rand_ram_addr() : rand_mmio_addr();
            step(r, e, w, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
